// File: rtl/upg_pkg.sv
// Shared definitions for the UART programming word loader: FSM states,
// frame header bytes and bus widths.
package upg_pkg;

    localparam int unsigned UPG_ADDR_W = 14;
    localparam int unsigned UPG_WORD_W = 32;
    localparam int unsigned UPG_BYTE_W = 8;

    localparam logic [7:0] UPG_HDR_INST   = 8'h00;
    localparam logic [7:0] UPG_HDR_DATA   = 8'h01;
    localparam logic [7:0] UPG_HDR_FINISH = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } upg_state_e;

endpackage

// File: rtl/upg_byte_packer.sv
// Little-endian byte-to-word packer: lane counter plus shift register.
// The word and ready flag are combinational so the caller can register them in the same cycle.
module upg_byte_packer
    import upg_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  byte_vld_i,
    input  logic [7:0]            byte_i,
    input  logic                  clr_i,
    output logic [UPG_WORD_W-1:0] word_c_o,
    output logic                  word_ready_c_o
);

    logic [1:0]            lane_q, lane_d;
    logic [UPG_WORD_W-1:0] shreg_q, shreg_d;

    // Bytes enter at the top, so after four strobes byte 0 sits in bits 7:0.
    always_comb begin
        lane_d  = lane_q;
        shreg_d = shreg_q;
        if (clr_i) begin
            lane_d  = '0;
            shreg_d = '0;
        end else if (byte_vld_i) begin
            lane_d  = lane_q + 2'd1;
            shreg_d = {byte_i, shreg_q[UPG_WORD_W-1:UPG_BYTE_W]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lane_q  <= '0;
            shreg_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_c_o       = {byte_i, shreg_q[UPG_WORD_W-1:UPG_BYTE_W]};
    assign word_ready_c_o = byte_vld_i && (lane_q == 2'd3);

endmodule

// File: rtl/upg_word_loader.sv
// UART programming loader: decodes segment frames and drives the memory write bus.
// Define UPG_CHECKSUM_EN to require a trailing XOR checksum byte per segment.
module upg_word_loader
    import upg_pkg::*;
#(
    parameter int unsigned ADDR_W     = UPG_ADDR_W,
    parameter logic [7:0]  HDR_INST   = UPG_HDR_INST,
    parameter logic [7:0]  HDR_DATA   = UPG_HDR_DATA,
    parameter logic [7:0]  HDR_FINISH = UPG_HDR_FINISH
) (
    input  logic                  upg_clk_i,
    input  logic                  upg_rst_n_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  upg_wen_o,
    output logic [ADDR_W:0]       upg_adr_o,
    output logic [UPG_WORD_W-1:0] upg_dat_o,
    output logic                  upg_done_o,
    output logic                  upg_err_o
);

    upg_state_e            state_q, state_d;
    logic                  tgt_q, tgt_d;
    logic [ADDR_W-1:0]     len_q, len_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic                  wen_q, wen_d;
    logic [ADDR_W:0]       adr_q, adr_d;
    logic [UPG_WORD_W-1:0] dat_q, dat_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  pk_clr_c;
    logic                  pk_vld_c;
    logic [UPG_WORD_W-1:0] pk_word_c;
    logic                  pk_ready_c;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    assign pk_vld_c = rx_valid_i && (state_q == ST_DATA);

    upg_byte_packer u_packer (
        .clk_i          (upg_clk_i),
        .rst_n_i        (upg_rst_n_i),
        .byte_vld_i     (pk_vld_c),
        .byte_i         (rx_data_i),
        .clr_i          (pk_clr_c),
        .word_c_o       (pk_word_c),
        .word_ready_c_o (pk_ready_c)
    );

    // Frame decoder; nothing moves unless a byte is presented.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        len_d    = len_q;
        idx_d    = idx_q;
        wen_d    = 1'b0;
        adr_d    = adr_q;
        dat_d    = dat_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clr_c = 1'b0;
`ifdef UPG_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (rx_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data_i == HDR_INST || rx_data_i == HDR_DATA) begin
                        tgt_d   = (rx_data_i == HDR_DATA);
                        state_d = ST_LEN0;
                    end else if (rx_data_i == HDR_FINISH) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
                ST_LEN0: begin
                    len_d   = ADDR_W'(rx_data_i);
                    state_d = ST_LEN1;
                end
                ST_LEN1: begin
                    // A zero length wraps to the full memory size via len_q - 1 below.
                    len_d    = ADDR_W'({rx_data_i, len_q[7:0]});
                    idx_d    = '0;
                    pk_clr_c = 1'b1;
`ifdef UPG_CHECKSUM_EN
                    csum_d   = '0;
`endif
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
`ifdef UPG_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data_i;
`endif
                    if (pk_ready_c) begin
                        wen_d = 1'b1;
                        adr_d = {tgt_q, idx_q};
                        dat_d = pk_word_c;
                        idx_d = idx_q + ADDR_W'(1);
                        if (idx_q == len_q - ADDR_W'(1)) begin
`ifdef UPG_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end
`ifdef UPG_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_data_i == csum_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            state_q <= ST_IDLE;
            tgt_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef UPG_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

endmodule

// File: tb/tb_upg_word_loader.sv
// Self-checking bench for upg_word_loader: randomized frames against a frame-level model.
// Honors UPG_CHECKSUM_EN when compiled with the same define as the RTL.
module tb_upg_word_loader;
    import upg_pkg::*;

    localparam int unsigned ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              wen;
    logic [ADDR_W:0]   adr;
    logic [31:0]       dat;
    logic              done;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int n_wen    = 0;
    int exp_wen  = 0;

    upg_word_loader dut (
        .upg_clk_i   (clk),
        .upg_rst_n_i (rst_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .upg_wen_o   (wen),
        .upg_adr_o   (adr),
        .upg_dat_o   (dat),
        .upg_done_o  (done),
        .upg_err_o   (err)
    );

    always #50 clk = ~clk;

    always @(negedge clk) if (wen === 1'b1) n_wen++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; returns on the next negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap(input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) @(negedge clk);
    endtask

    task automatic sync_count(input string tag);
        repeat (2) @(negedge clk);
        check_eq(tag, 32'(n_wen), 32'(exp_wen));
    endtask

    // Sends one frame of n words; every word must appear on the bus right after its last byte.
    task automatic send_segment(input bit tgt, input int n, input int max_gap,
                                input bit fine, input bit pat, input bit bad_cs);
        logic [7:0]  cs;
        logic [15:0] len;
        cs  = 8'h00;
        len = 16'(n % 16384);
        send_byte(tgt ? UPG_HDR_DATA : UPG_HDR_INST); gap(max_gap);
        send_byte(len[7:0]);                          gap(max_gap);
        send_byte(len[15:8]);                         gap(max_gap);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            logic [7:0]  pb;
            pb = 8'hAA + 8'(i * 17);
            w  = pat ? {4{pb}} : 32'($urandom);
            for (int l = 0; l < 4; l++) begin
                logic [31:0] sh;
                sh = w >> (8 * l);
                cs = cs ^ sh[7:0];
                send_byte(sh[7:0]);
                if (l == 3) begin
                    exp_wen++;
                    check_eq("wen_pulse", 32'(wen), 32'd1);
                    check_eq("adr", 32'(adr), 32'(tgt) * 32'd16384 + 32'(i));
                    check_eq("dat", dat, w);
                end else if (fine) begin
                    check_eq("wen_quiet", 32'(wen), 32'd0);
                end
                if (max_gap > 0 && fine && l == 3) begin
                    int g;
                    g = int'($urandom_range(max_gap, 0));
                    if (g > 0) begin
                        @(negedge clk);
                        check_eq("wen_one_cycle", 32'(wen), 32'd0);
                        check_eq("dat_hold", dat, w);
                        repeat (g - 1) @(negedge clk);
                    end
                end else begin
                    gap(max_gap);
                end
            end
        end
`ifdef UPG_CHECKSUM_EN
        send_byte(bad_cs ? (cs ^ 8'h01) : cs);
`else
        if (bad_cs) cs = ~cs;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_eq("rst_wen",  32'(wen),  32'd0);
        check_eq("rst_adr",  32'(adr),  32'd0);
        check_eq("rst_dat",  dat,       32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err",  32'(err),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset();

        // Single instruction word then finish.
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        exp_wen++;
        check_eq("tp1_wen", 32'(wen), 32'd1);
        check_eq("tp1_adr", 32'(adr), 32'h0000);
        check_eq("tp1_dat", dat, 32'h12345678);
`ifdef UPG_CHECKSUM_EN
        send_byte(8'h08);
`endif
        check_eq("tp1_done_before", 32'(done), 32'd0);
        send_byte(8'hFF);
        check_eq("tp1_done", 32'(done), 32'd1);
        check_eq("tp1_err", 32'(err), 32'd0);
        // Everything after done is ignored.
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        sync_count("after_done_no_write");
        check_eq("done_sticky", 32'(done), 32'd1);

        // Two data-memory words, then random segments with idle gaps.
        do_reset();
        send_segment(1'b1, 2, 0, 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 12; s++)
            send_segment(1'($urandom), int'($urandom_range(6, 1)), 2, 1'b1, 1'b0, 1'b0);
        sync_count("random_segments");
        check_eq("rand_done_before", 32'(done), 32'd0);
        send_byte(UPG_HDR_FINISH);
        check_eq("rand_done", 32'(done), 32'd1);
        check_eq("rand_err", 32'(err), 32'd0);

        // Reset in the middle of a segment discards the partial word.
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD);
        do_reset();
        send_segment(1'b0, 1, 1, 1'b1, 1'b0, 1'b0);
        sync_count("mid_reset");

        // Full-size segment, back to back; FSM must return to IDLE afterwards.
        send_segment(1'b0, 16384, 0, 1'b0, 1'b0, 1'b0);
        check_eq("big_last_adr", 32'(adr), 32'h3FFF);
        send_segment(1'b1, 1, 0, 1'b1, 1'b0, 1'b0);
        sync_count("big_segment");
        check_eq("big_err", 32'(err), 32'd0);

        // Unknown header is a sticky error and blocks done.
        do_reset();
        send_byte(8'h55);
        check_eq("bad_hdr_err", 32'(err), 32'd1);
        check_eq("bad_hdr_done", 32'(done), 32'd0);
        send_byte(8'hFF);
        check_eq("bad_hdr_ff_done", 32'(done), 32'd0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        sync_count("bad_hdr_no_write");
        check_eq("bad_hdr_err_sticky", 32'(err), 32'd1);

`ifdef UPG_CHECKSUM_EN
        // Good checksum returns to IDLE; a bad one errors after the write.
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        exp_wen++;
        check_eq("cs_dat", dat, 32'h04030201);
        send_byte(8'h04);
        check_eq("cs_ok_err", 32'(err), 32'd0);
        send_segment(1'b1, 2, 1, 1'b1, 1'b0, 1'b0);
        sync_count("cs_ok_idle");
        send_segment(1'b0, 1, 0, 1'b1, 1'b0, 1'b1);
        check_eq("cs_bad_err", 32'(err), 32'd1);
        send_byte(8'hFF);
        check_eq("cs_bad_done", 32'(done), 32'd0);
        sync_count("cs_bad_count");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upg_word_loader.md
# upg_word_loader

Upstream feeder of the UART programming path: it consumes the byte stream from the UART receiver, decodes segment headers, packs bytes little-endian into 32-bit words, and drives the write-side programming bus (write enable, address, data, done) shared by instruction and data memory. It runs entirely in the programming clock domain. It is the only source of the done flag that hands memory ports back to the CPU.

## Interface
Parameters:
- ADDR_W, 14: word-address width per memory (16384 words).
- HDR_INST, 8'h00: header byte selecting instruction memory.
- HDR_DATA, 8'h01: header byte selecting data memory.
- HDR_FINISH, 8'hFF: header byte ending programming.

Ports:
- upg_clk_i  in  1  programming clock (10 MHz); the only clock.
- upg_rst_n_i  in  1  asynchronous, active-low reset.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i valid. May be high on consecutive cycles.
- rx_data_i  in  8  received byte.
- upg_wen_o  out  1  one-cycle write strobe.
- upg_adr_o  out  ADDR_W+1  bit ADDR_W = target (0 instruction, 1 data); low bits = word index.
- upg_dat_o  out  32  assembled word.
- upg_done_o  out  1  sticky; programming finished.
- upg_err_o  out  1  sticky; protocol error.

## Operation
- Frame: header byte, then LEN_LO, LEN_HI (word count N, little-endian; 0 encodes 16384), then 4·N data bytes (byte 0 = bits 7:0).
- States: IDLE, LEN0, LEN1, DATA, CHK (only with the macro), DONE, ERR.
- IDLE:
  - HDR_INST or HDR_DATA: latch the target bit and go to LEN0.
  - HDR_FINISH: go to DONE.
  - Any other byte: go to ERR.
- LEN0 → LEN1 → DATA. Word index clears to 0 and byte lane to 0 on entry to DATA.
- DATA: each byte fills lane 0..3. On lane 3, issue a write at the current index, then increment the index.
  - After word N, go to CHK if the checksum is compiled in, otherwise go to IDLE.
- DONE: upg_done_o=1; all bytes are ignored until reset.
- ERR: upg_err_o=1, upg_done_o stays 0; all bytes are ignored until reset.
- Segments may repeat in any order. A later segment overwrites earlier words at the same address.

## Timing
- Reset: all outputs 0, state IDLE, partial word discarded. Reset asserted mid-segment aborts the segment with no write issued.
- Write strobe:
  - upg_wen_o is high for exactly the cycle after the rx_valid_i that carries byte lane 3.
  - upg_adr_o and upg_dat_o are stable in that cycle and hold until the next write.
- upg_done_o rises the cycle after HDR_FINISH is accepted.
- Back-to-back rx_valid_i on every cycle is sustained with no byte loss. No backpressure exists.
- Index width: ADDR_W bits; with N=16384 the last write uses index 16383 and the counter never wraps inside a segment.
- Cycles with rx_valid_i=0 leave all state unchanged.

## Configuration
- UPG_CHECKSUM_EN defined:
  - After the last data byte, the FSM enters CHK and expects one byte equal to the XOR of all 4·N data bytes of the segment.
  - Match: return to IDLE.
  - Mismatch: go to ERR. Writes already issued are not retracted, and done is never asserted.
- Undefined: no CHK state. DATA returns directly to IDLE.

## Structure
- Shared package upg_pkg: the state enum, the header constants, and ADDR_W.
- One sub-module, upg_byte_packer: lane counter and 32-bit shift/assemble register. Inputs: byte strobe and a clear signal. Outputs: word and word_ready.
- The top level holds the FSM, length and index counters, the checksum accumulator, and the output registers.

## Test plan
- Reset then bytes 00,01,00,78,56,34,12,FF → one upg_wen_o pulse with adr=15'h0000 and dat=32'h12345678; upg_done_o=1 one cycle after FF; err=0.
- Bytes 01,02,00 then words AAAAAAAA, BBBBBBBB, then FF → writes at adr 15'h4000 and 15'h4001 with those values; then done=1.
- Header byte 0x55 in IDLE → err=1, done=0. A following FF does not raise done.
- LEN bytes 00,00 followed by 65536 bytes → 16384 writes; last adr=15'h3FFF; FSM back in IDLE.
- upg_rst_n_i pulsed low after 2 data bytes, then a full frame 00,01,00,… → only the new word is written, at index 0.
- With UPG_CHECKSUM_EN, frame 00,01,00,01,02,03,04 then checksum 04 → write occurs and FSM returns to IDLE. With checksum 05 → err=1.
